data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory interface. The MEM pipeline stage is the initiator; this block is the word-organised data RAM that serves its load and store requests.
- Loads and stores complete through a valid/ready request channel and a one-cycle response pulse. A configurable number of wait states models slow memory and exercises pipeline stall logic.
- A second, independent read-only port drives the board LED display.

Parameters:
- ADDR_W, 10, word-address width; memory holds 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 1, extra cycles between request acceptance and response; 0..15 legal.
- LED_BASE, 0, word index of the first of the 16 words visible on the LED port.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as error).
- req_signed  input  1  sign-extend a byte or half load.
- req_addr  input  32  byte address (ALU result).
- req_wdata  input  32  store data; low bytes are used for sub-word stores.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  load data, aligned to bit 0 and extended.
- resp_err  output  1  access was misaligned or used a reserved size.
- led_addr  input  4  LED word select.
- led_data  output  32  contents of word LED_BASE+led_addr.

Behaviour:
- Reset values: resp_valid=0, resp_rdata=0, resp_err=0, led_data=0, req_ready=1. The RAM array is not cleared.

States:
- IDLE (req_ready=1):
  - Request accepted when req_valid=1.
  - All request fields are captured into registers.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT (req_ready=0):
  - A down-counter is loaded with WAIT_CYCLES-1 on acceptance.
  - Moves to RESP when the counter reaches 0.
- RESP (req_ready=0):
  - resp_valid=1 for exactly this cycle, with resp_rdata and resp_err valid.
  - Returns to IDLE; a new request can be accepted on the following cycle.

Latency and throughput:
- Acceptance at cycle T gives resp_valid at T+1+WAIT_CYCLES.
- Back-to-back throughput is one request per WAIT_CYCLES+2 cycles.

Address and data rules:
- Word index = req_addr[ADDR_W+1:2]. Upper address bits are ignored (wrap-around).
- Byte lanes are little-endian: byte at offset k occupies bits 8k+7:8k.

Alignment:
- A half access needs addr[0]=0. A word access needs addr[1:0]=0.
- A violation, or req_size=11, sets resp_err=1 and resp_rdata=0, and memory is not modified.
- A response is still given after the normal latency.

Loads:
- resp_rdata holds the selected byte or half in the low bits.
- Upper bits are sign-extended when req_signed=1, otherwise zero-filled.
- Word loads ignore req_signed.

Stores:
- Only the addressed byte lanes are written.
- The write is committed on the clock edge that enters RESP.
- Store responses return resp_rdata=0.

Reset mid-operation:
- rst in WAIT or RESP aborts the access. A pending store that has not reached RESP is discarded.
- State returns to IDLE with reset outputs.

LED port:
- led_data is a registered read of word LED_BASE+led_addr every cycle, independent of the FSM.
- If a store commits to the same word on the same edge, led_data shows the old value (read-before-write). The new value appears one cycle later.

Outputs:
- resp_rdata and resp_err hold their last values outside RESP.
- Consumers must qualify them with resp_valid.

Decomposition:
- Shared package:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state encodings IDLE, WAIT, RESP;
  - a function computing the 4-bit byte-enable from size and addr[1:0].
- One natural sub-module, dmem_lane_align: combinational store-data replication and byte-enable, plus load-data extraction and extension.
- The FSM, counter and RAM array stay in the top module.

Test Plan:
- Word store, then load, with WAIT_CYCLES=1:
  - store 0xDEADBEEF to addr 0x10, accepted at cycle 0;
  - resp_valid at cycle 2 with err=0;
  - a load of 0x10 returns 0xDEADBEEF;
  - req_ready is low during cycles 1-2.
- Sub-word loads of word 0x10 = 0x8070F0A5:
  - lb signed addr 0x10 -> 0xFFFFFFA5;
  - lbu addr 0x11 -> 0x000000F0;
  - lh signed addr 0x12 -> 0xFFFF8070;
  - lhu addr 0x12 -> 0x00008070.
- Byte store of 0x12345678 to addr 0x21 over word 0 -> word 0x20 reads 0x00007800.
- Misaligned word load at 0x13 and half store at 0x15:
  - resp_err=1 and resp_rdata=0;
  - word 0x14 is unchanged.
- rst asserted in WAIT during a store of 0xCAFEBABE to 0x30 (WAIT_CYCLES=3):
  - no resp_valid;
  - req_ready=1 the next cycle;
  - a load of 0x30 returns the old value.
- LED port: led_addr=2 while a store commits to word LED_BASE+2:
  - led_data shows the old value on the commit edge;
  - led_data shows the new value one cycle later.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared encodings and lane helpers for the data-memory responder.
// Size codes, FSM states, byte-enable and access-error derivation.
package data_mem_responder_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Byte lanes touched by an access; all-zero for misaligned or reserved accesses.
   function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         SZ_BYTE: be = 4'b0001 << off;
         SZ_HALF: be = off[0] ? 4'b0000 : (4'b0011 << off);
         SZ_WORD: be = (off == 2'b00) ? 4'b1111 : 4'b0000;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
      logic err;
      err = 1'b0;
      case (size)
         SZ_BYTE: err = 1'b0;
         SZ_HALF: err = off[0];
         SZ_WORD: err = (off != 2'b00);
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store-data replication and byte enables,
// plus load-data extraction with sign or zero extension.
module dmem_lane_align
   import data_mem_responder_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata,
   output logic        o_err
);

   logic [31:0] w_shift;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign o_be  = byte_enable(i_size, i_off);
   assign o_err = access_err(i_size, i_off);

   // Replicate the low bytes across all lanes; the byte enable picks the live ones.
   always_comb begin
      o_wdata = i_wdata;
      case (i_size)
         SZ_BYTE: o_wdata = {4{i_wdata[7:0]}};
         SZ_HALF: o_wdata = {2{i_wdata[15:0]}};
         default: o_wdata = i_wdata;
      endcase
   end

   always_comb begin
      w_shift = i_rword >> {i_off, 3'b000};
      w_byte  = w_shift[7:0];
      w_half  = w_shift[15:0];
      o_rdata = 32'h0;
      if (!o_err) begin
         case (i_size)
            SZ_BYTE: o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_rdata = {{16{i_signed & w_half[15]}}, w_half};
            SZ_WORD: o_rdata = i_rword;
            default: o_rdata = 32'h0;
         endcase
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data RAM answering MEM-stage loads/stores with configurable
// wait states, plus an independent registered LED read port.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1,
   parameter int LED_BASE    = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   input  logic [3:0]  led_addr,
   output logic [31:0] led_data
);

   localparam int                DEPTH    = 1 << ADDR_W;
   localparam logic [3:0]        CNT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [ADDR_W-1:0] LED_IDX  = ADDR_W'(LED_BASE);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_nxt;

   logic              r_write;
   logic              r_signed;
   logic [1:0]        r_size;
   logic [1:0]        r_off;
   logic [ADDR_W-1:0] r_idx;
   logic [31:0]       r_wdata;

   logic [31:0]       r_mem [DEPTH];
   logic              r_resp_valid;
   logic [31:0]       r_resp_rdata;
   logic              r_resp_err;
   logic [31:0]       r_led;

   logic              w_accept;
   logic              w_enter_resp;
   logic              w_cur_write;
   logic              w_cur_signed;
   logic [1:0]        w_cur_size;
   logic [1:0]        w_cur_off;
   logic [ADDR_W-1:0] w_cur_idx;
   logic [31:0]       w_cur_wdata;
   logic [31:0]       w_rword;
   logic [3:0]        w_be;
   logic [31:0]       w_wrep;
   logic [31:0]       w_rdata_ext;
   logic              w_err;
   logic [ADDR_W-1:0] w_led_idx;
   logic              w_unused_addr;

   assign req_ready    = (r_state == IDLE);
   assign resp_valid   = r_resp_valid;
   assign resp_rdata   = r_resp_rdata;
   assign resp_err     = r_resp_err;
   assign led_data     = r_led;
   assign w_accept     = (r_state == IDLE) && req_valid;
   assign w_enter_resp = (w_state_nxt == RESP);
   assign w_unused_addr = ^req_addr[31:ADDR_W+2];

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_cnt_nxt   = CNT_LOAD;
               w_state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = RESP;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // With no wait states the access completes on its acceptance edge, so the
   // live request fields stand in for the not-yet-loaded captured ones.
   always_comb begin
      w_cur_write  = r_write;
      w_cur_signed = r_signed;
      w_cur_size   = r_size;
      w_cur_off    = r_off;
      w_cur_idx    = r_idx;
      w_cur_wdata  = r_wdata;
      if (r_state == IDLE) begin
         w_cur_write  = req_write;
         w_cur_signed = req_signed;
         w_cur_size   = req_size;
         w_cur_off    = req_addr[1:0];
         w_cur_idx    = req_addr[ADDR_W+1:2];
         w_cur_wdata  = req_wdata;
      end
   end

   assign w_rword   = r_mem[w_cur_idx];
   assign w_led_idx = LED_IDX + ADDR_W'(led_addr);

   dmem_lane_align u_align (
      .i_size   (w_cur_size),
      .i_signed (w_cur_signed),
      .i_off    (w_cur_off),
      .i_wdata  (w_cur_wdata),
      .i_rword  (w_rword),
      .o_be     (w_be),
      .o_wdata  (w_wrep),
      .o_rdata  (w_rdata_ext),
      .o_err    (w_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cnt        <= 4'd0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'h0;
         r_resp_err   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_resp_valid <= w_enter_resp;
         if (w_enter_resp) begin
            r_resp_err   <= w_err;
            r_resp_rdata <= w_cur_write ? 32'h0 : w_rdata_ext;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_write  <= 1'b0;
         r_signed <= 1'b0;
         r_size   <= SZ_BYTE;
         r_off    <= 2'b00;
         r_idx    <= '0;
         r_wdata  <= 32'h0;
      end else if (w_accept) begin
         r_write  <= req_write;
         r_signed <= req_signed;
         r_size   <= req_size;
         r_off    <= req_addr[1:0];
         r_idx    <= req_addr[ADDR_W+1:2];
         r_wdata  <= req_wdata;
      end
   end

   // Stores land on the edge entering RESP; a reset on that edge drops them.
   always_ff @(posedge clk) begin
      if (!rst && w_enter_resp && w_cur_write && !w_err) begin
         for (int k = 0; k < 4; k++) begin
            if (w_be[k]) begin
               r_mem[w_cur_idx][8*k +: 8] <= w_wrep[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_led <= 32'h0;
      end else begin
         r_led <= r_mem[w_led_idx];
      end
   end

endmodule
